// File: rtl/truth_table_sweeper.sv
// Drives a 3-input logic block through rows 0..7, waits for a settled and stable output
// per row, assembles an 8-bit truth table (row r -> bit 7-r) and compares it to EXPECTED_TT.
// Steady-output latency: the start cycle through the done cycle spans 8*(SETTLE_CYCLES+STABLE_CYCLES)+2 cycles.
module truth_table_sweeper #(
  parameter logic [7:0] EXPECTED_TT    = 8'h65,
  parameter int         SETTLE_CYCLES  = 16,
  parameter int         STABLE_CYCLES  = 4,
  parameter int         TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [2:0] dut_in,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt_value,
  output logic       match,
  output logic       error,
  output logic [2:0] err_row
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int BW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [BW-1:0] STABLE_MAX  = BW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_APPLY,
    S_SAMPLE,
    S_FINISH
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      row_q, row_d;
  logic [2:0]      dut_in_q, dut_in_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [BW-1:0]   stable_q, stable_d, stable_inc;
  logic [TW-1:0]   timeout_q, timeout_d, timeout_inc;
  logic [7:0]      tt_q, tt_d;
  logic            match_q, match_d;
  logic            error_q, error_d;
  logic [2:0]      err_row_q, err_row_d;
  logic            sync1_q, s_out_q, s_prev_q;

  // NOTE: every variable gets a default before the case, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    dut_in_d  = dut_in_q;
    settle_d  = settle_q;
    stable_d  = stable_q;
    timeout_d = timeout_q;
    tt_d      = tt_q;
    match_d   = match_q;
    error_d   = error_q;
    err_row_d = err_row_q;

    stable_inc  = (s_out_q == s_prev_q) ? stable_q + BW'(1) : BW'(1);
    timeout_inc = timeout_q + TW'(1);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_APPLY;
          row_d     = 3'd0;
          dut_in_d  = 3'd0;
          settle_d  = '0;
          tt_d      = 8'h00;
          match_d   = 1'b0;
          error_d   = 1'b0;
          err_row_d = 3'd0;
        end
      end
      S_APPLY: begin
        if (settle_q == SETTLE_LAST) begin
          state_d   = S_SAMPLE;
          stable_d  = '0;
          timeout_d = '0;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      S_SAMPLE: begin
        stable_d  = stable_inc;
        timeout_d = timeout_inc;
        // A capture on the last allowed sampling cycle still wins over the timeout.
        if (stable_inc == STABLE_MAX) begin
          tt_d[3'd7 - row_q] = s_out_q;
          if (row_q == 3'd7) begin
            state_d = S_FINISH;
          end else begin
            state_d  = S_APPLY;
            row_d    = row_q + 3'd1;
            dut_in_d = row_q + 3'd1;
            settle_d = '0;
          end
        end else if (timeout_inc == TIMEOUT_MAX) begin
          state_d   = S_FINISH;
          error_d   = 1'b1;
          err_row_d = row_q;
        end
      end
      S_FINISH: begin
        state_d  = S_IDLE;
        dut_in_d = 3'd0;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q == S_APPLY || state_q == S_SAMPLE)) begin
      state_d   = S_IDLE;
      dut_in_d  = 3'd0;
      tt_d      = tt_q;
      error_d   = error_q;
      err_row_d = err_row_q;
      match_d   = 1'b0;
    end

    // match is registered on the FINISH entry edge so it is valid together with done.
    if (state_d == S_FINISH) begin
      match_d = (tt_d == EXPECTED_TT) && !error_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      row_q     <= 3'd0;
      dut_in_q  <= 3'd0;
      settle_q  <= '0;
      stable_q  <= '0;
      timeout_q <= '0;
      tt_q      <= 8'h00;
      match_q   <= 1'b0;
      error_q   <= 1'b0;
      err_row_q <= 3'd0;
      sync1_q   <= 1'b0;
      s_out_q   <= 1'b0;
      s_prev_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      dut_in_q  <= dut_in_d;
      settle_q  <= settle_d;
      stable_q  <= stable_d;
      timeout_q <= timeout_d;
      tt_q      <= tt_d;
      match_q   <= match_d;
      error_q   <= error_d;
      err_row_q <= err_row_d;
      sync1_q   <= dut_out;
      s_out_q   <= sync1_q;
      s_prev_q  <= s_out_q;
    end
  end

  assign dut_in   = dut_in_q;
  assign busy     = (state_q == S_APPLY) || (state_q == S_SAMPLE);
  assign done     = (state_q == S_FINISH);
  assign tt_value = tt_q;
  assign match    = match_q;
  assign error    = error_q;
  assign err_row  = err_row_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a behavioural logic-block model (truth table, glitch window,
// stuck-toggling row) drives dut_out; expectations come from truth tables and latency formulas.
module tb_truth_table_sweeper;

  localparam int S   = 16;
  localparam int T   = 4;
  localparam int TO  = 256;
  localparam int NOM = 8 * (S + T) + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       dut_out = 1'b0;
  logic [2:0] dut_in;
  logic       busy, done, match, error;
  logic [7:0] tt_value;
  logic [2:0] err_row;

  int vectors = 0;
  int miscompares = 0;

  // logic-block model configuration
  logic [7:0] model_tt = 8'h00;
  int         glitch_len = 0;
  int         toggle_row = -1;
  logic [2:0] last_in = 3'd0;
  int         since = 1000;

  always #5 clk = ~clk;

  truth_table_sweeper #(
    .EXPECTED_TT   (8'h65),
    .SETTLE_CYCLES (S),
    .STABLE_CYCLES (T),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .dut_in  (dut_in),
    .dut_out (dut_out),
    .busy    (busy),
    .done    (done),
    .tt_value(tt_value),
    .match   (match),
    .error   (error),
    .err_row (err_row)
  );

  // Logic block: reacts to dut_in a half cycle later; may glitch or toggle forever on one row.
  always @(negedge clk) begin
    if (dut_in !== last_in) begin
      last_in = dut_in;
      since = 0;
    end else if (since < 1000) begin
      since++;
    end
    if (toggle_row >= 0 && int'(dut_in) == toggle_row) dut_out = ~dut_out;
    else if (since < glitch_len) begin
      if (since % 2 == 1) dut_out = ~dut_out;
    end else dut_out = model_tt[3'd7 - dut_in];
  end

  function automatic logic [7:0] tt_of(input int kind);
    logic [7:0] t;
    t = 8'h00;
    for (int r = 0; r < 8; r++) begin
      logic a, b, c;
      a = r[2]; b = r[1]; c = r[0];
      if (kind == 0) t[7-r] = (~a & b) ^ c;
      else           t[7-r] = a & b & c;
    end
    return t;
  endfunction

  // One sweep: pulses start, optionally pokes start while busy, measures start-to-done cycles
  // (start cycle = 1), counts done pulses and cycles where busy was wrong.
  task automatic run_sweep(input bit poke, output int lat, output int dones, output int busy_bad);
    int  idx;
    bit  seen;
    lat = -1; dones = 0; busy_bad = 0; seen = 0;
    @(negedge clk); start = 1'b1; idx = 1;
    while (!seen && idx < 3000) begin
      @(negedge clk); idx++;
      start = poke && (idx % 37 == 0);
      if (done === 1'b1) begin
        seen = 1; lat = idx; dones++; start = 1'b0;
        if (busy !== 1'b0) busy_bad++;
      end else if (busy !== 1'b1) busy_bad++;
    end
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (busy !== 1'b0) busy_bad++;
    end
  endtask

  task automatic test_reset();
    vectors++; if ({busy, done, match, error} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags: got %b want 0000", {busy, done, match, error}); end
    vectors++; if ({dut_in, err_row, tt_value} !== 14'h0) begin miscompares++; $display("FAIL reset_vals: got dut_in=%0d err_row=%0d tt=%h want zeros", dut_in, err_row, tt_value); end
  endtask

  task automatic test_match();
    int lat, dn, bb;
    logic [7:0] exp_tt;
    exp_tt = tt_of(0); model_tt = exp_tt; glitch_len = 0; toggle_row = -1;
    run_sweep(0, lat, dn, bb);
    vectors++; if (tt_value !== exp_tt) begin miscompares++; $display("FAIL match_tt: got %h want %h", tt_value, exp_tt); end
    vectors++; if ({match, error} !== {exp_tt == 8'h65, 1'b0}) begin miscompares++; $display("FAIL match_flags: got match=%b error=%b want 1 0", match, error); end
    vectors++; if (lat !== NOM) begin miscompares++; $display("FAIL match_latency: got %0d want %0d", lat, NOM); end
    vectors++; if (dn !== 1 || bb !== 0) begin miscompares++; $display("FAIL match_handshake: got dones=%0d busy_bad=%0d want 1 0", dn, bb); end
  endtask

  task automatic test_mismatch();
    int lat, dn, bb;
    logic [7:0] exp_tt;
    exp_tt = tt_of(1); model_tt = exp_tt; glitch_len = 0; toggle_row = -1;
    run_sweep(0, lat, dn, bb);
    vectors++; if (tt_value !== exp_tt) begin miscompares++; $display("FAIL mismatch_tt: got %h want %h", tt_value, exp_tt); end
    vectors++; if ({match, error} !== 2'b00) begin miscompares++; $display("FAIL mismatch_flags: got match=%b error=%b want 0 0", match, error); end
    vectors++; if (lat !== NOM || dn !== 1) begin miscompares++; $display("FAIL mismatch_timing: got lat=%0d dones=%0d want %0d 1", lat, dn, NOM); end
  endtask

  task automatic test_glitch();
    int lat, dn, bb;
    model_tt = tt_of(0); glitch_len = 20; toggle_row = -1;
    run_sweep(0, lat, dn, bb);
    glitch_len = 0;
    vectors++; if (tt_value !== 8'h65 || match !== 1'b1) begin miscompares++; $display("FAIL glitch_tt: got tt=%h match=%b want 65 1", tt_value, match); end
    vectors++; if (lat <= NOM || dn !== 1 || bb !== 0) begin miscompares++; $display("FAIL glitch_timing: got lat=%0d dones=%0d busy_bad=%0d want >%0d 1 0", lat, dn, bb, NOM); end
  endtask

  task automatic test_timeout();
    int lat, dn, bb, exp_lat;
    logic [7:0] exp_tt;
    model_tt = tt_of(0); glitch_len = 0; toggle_row = 3;
    exp_tt = model_tt & 8'hE0;
    exp_lat = 1 + 3 * (S + T) + S + TO + 1;
    run_sweep(0, lat, dn, bb);
    toggle_row = -1;
    vectors++; if ({error, err_row} !== {1'b1, 3'd3}) begin miscompares++; $display("FAIL timeout_err: got error=%b err_row=%0d want 1 3", error, err_row); end
    vectors++; if (tt_value !== exp_tt || match !== 1'b0) begin miscompares++; $display("FAIL timeout_tt: got tt=%h match=%b want %h 0", tt_value, match, exp_tt); end
    vectors++; if (lat !== exp_lat || dn !== 1) begin miscompares++; $display("FAIL timeout_latency: got lat=%0d dones=%0d want %0d 1", lat, dn, exp_lat); end
  endtask

  task automatic test_abort_restart();
    int lat, dn, bb, n, extra;
    model_tt = tt_of(0); glitch_len = 0; toggle_row = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (dut_in !== 3'd5 && n < 500) begin @(negedge clk); n++; end
    vectors++; if (dut_in !== 3'd5) begin miscompares++; $display("FAIL abort_reach_row5: got dut_in=%0d want 5", dut_in); end
    repeat (S + 1) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++; if ({busy, done, dut_in} !== 5'b0) begin miscompares++; $display("FAIL abort_stop: got busy=%b done=%b dut_in=%0d want 0 0 0", busy, done, dut_in); end
    vectors++; if (tt_value !== (model_tt & 8'hF8) || match !== 1'b0) begin miscompares++; $display("FAIL abort_partial: got tt=%h match=%b want %h 0", tt_value, match, model_tt & 8'hF8); end
    extra = 0;
    for (int k = 0; k < 2 * (S + T); k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy !== 1'b0) extra++;
    end
    vectors++; if (extra !== 0) begin miscompares++; $display("FAIL abort_quiet: got %0d active cycles want 0", extra); end
    run_sweep(0, lat, dn, bb);
    vectors++; if (tt_value !== 8'h65 || match !== 1'b1 || error !== 1'b0) begin miscompares++; $display("FAIL restart_result: got tt=%h match=%b error=%b want 65 1 0", tt_value, match, error); end
    vectors++; if (lat !== NOM || dn !== 1) begin miscompares++; $display("FAIL restart_timing: got lat=%0d dones=%0d want %0d 1", lat, dn, NOM); end
  endtask

  task automatic test_async_reset();
    int lat, dn, bb, n;
    model_tt = tt_of(0); glitch_len = 0; toggle_row = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (dut_in !== 3'd2 && n < 500) begin @(negedge clk); n++; end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({busy, done, match, error} !== 4'b0000) begin miscompares++; $display("FAIL areset_flags: got %b want 0000", {busy, done, match, error}); end
    vectors++; if ({dut_in, err_row, tt_value} !== 14'h0) begin miscompares++; $display("FAIL areset_vals: got dut_in=%0d err_row=%0d tt=%h want zeros", dut_in, err_row, tt_value); end
    @(negedge clk); rst_n = 1'b1;
    run_sweep(1, lat, dn, bb);
    vectors++; if (tt_value !== 8'h65 || match !== 1'b1) begin miscompares++; $display("FAIL areset_sweep: got tt=%h match=%b want 65 1", tt_value, match); end
    vectors++; if (lat !== NOM || dn !== 1 || bb !== 0) begin miscompares++; $display("FAIL areset_pokes: got lat=%0d dones=%0d busy_bad=%0d want %0d 1 0", lat, dn, bb, NOM); end
  endtask

  task automatic test_random();
    int lat, dn, bb;
    logic [7:0] f;
    for (int i = 0; i < 5; i++) begin
      f = (i == 1) ? 8'h65 : 8'($urandom);
      model_tt = f; glitch_len = $urandom_range(0, 40); toggle_row = -1;
      run_sweep(i[0], lat, dn, bb);
      vectors++; if (tt_value !== f) begin miscompares++; $display("FAIL random_tt[%0d]: got %h want %h", i, tt_value, f); end
      vectors++; if ({match, error} !== {f == 8'h65, 1'b0}) begin miscompares++; $display("FAIL random_flags[%0d]: got match=%b error=%b want %b 0", i, match, error, f == 8'h65); end
      vectors++; if (lat < NOM || dn !== 1 || bb !== 0) begin miscompares++; $display("FAIL random_timing[%0d]: got lat=%0d dones=%0d busy_bad=%0d", i, lat, dn, bb); end
    end
    glitch_len = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_match();
    test_mismatch();
    test_glitch();
    test_timeout();
    test_abort_restart();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
